// File: rtl/temporizador_mmss.sv
// MM:SS BCD countdown timer driven by rising edges of the divided square wave div_frec.
// Optional build macro TEMP_AUTORELOAD_EN: on expiry reload from the preset and keep running.
module temporizador_mmss (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        div_frec,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  input  logic [15:0] preset,
  output logic [3:0]  min_dec,
  output logic [3:0]  min_uni,
  output logic [3:0]  seg_dec,
  output logic [3:0]  seg_uni,
  output logic        running,
  output logic        done,
  output logic        fin
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_prev;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nx;
  logic        r_running;
  logic        r_done;
  logic        r_fin;
  logic        w_fin_nx;
  logic        w_tick;
  logic        w_cnt_zero;
  logic        w_cnt_one;
  logic [15:0] w_clamped;
  logic [15:0] w_cnt_dec;
`ifdef TEMP_AUTORELOAD_EN
  logic [15:0] r_preset;
  logic [15:0] w_preset_nx;
`endif

  // Digits above 9 saturate at 9; tens of seconds saturate at 5.
  function automatic logic [15:0] f_clamp(input logic [15:0] p);
    logic [3:0] md, mu, sd, su;
    md = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
    mu = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    sd = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    su = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return {md, mu, sd, su};
  endfunction

  // BCD borrow chain; callers guarantee the count is non-zero.
  function automatic logic [15:0] f_dec(input logic [15:0] c);
    logic [3:0] md, mu, sd, su;
    md = c[15:12];
    mu = c[11:8];
    sd = c[7:4];
    su = c[3:0];
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (sd != 4'd0) begin
        sd = sd - 4'd1;
      end else begin
        sd = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          md = md - 4'd1;
        end
      end
    end
    return {md, mu, sd, su};
  endfunction

  assign w_tick     = div_frec & ~r_prev;
  assign w_cnt_zero = (r_cnt == 16'h0000);
  assign w_cnt_one  = (r_cnt == 16'h0001);
  assign w_clamped  = f_clamp(preset);
  assign w_cnt_dec  = f_dec(r_cnt);

  // Priority: load > pause > start > tick.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_fin_nx   = 1'b0;
`ifdef TEMP_AUTORELOAD_EN
    w_preset_nx = r_preset;
`endif
    if (load) begin
      w_cnt_nx   = w_clamped;
      w_state_nx = S_IDLE;
`ifdef TEMP_AUTORELOAD_EN
      w_preset_nx = w_clamped;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!pause && start && !w_cnt_zero) w_state_nx = S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            w_state_nx = S_PAUSE;
          end else if (w_tick) begin
            if (w_cnt_one) begin
              w_fin_nx = 1'b1;
`ifdef TEMP_AUTORELOAD_EN
              w_cnt_nx = r_preset;
`else
              w_cnt_nx   = '0;
              w_state_nx = S_DONE;
`endif
            end else if (!w_cnt_zero) begin
              w_cnt_nx = w_cnt_dec;
            end
          end
        end
        S_PAUSE: begin
          if (!pause && start) w_state_nx = S_RUN;
        end
        S_DONE: begin
          w_state_nx = S_DONE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_prev    <= 1'b1;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_fin     <= 1'b0;
`ifdef TEMP_AUTORELOAD_EN
      r_preset  <= '0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_prev    <= div_frec;
      r_cnt     <= w_cnt_nx;
      r_running <= (w_state_nx == S_RUN);
      r_done    <= (w_state_nx == S_DONE);
      r_fin     <= w_fin_nx;
`ifdef TEMP_AUTORELOAD_EN
      r_preset  <= w_preset_nx;
`endif
    end
  end

  assign min_dec = r_cnt[15:12];
  assign min_uni = r_cnt[11:8];
  assign seg_dec = r_cnt[7:4];
  assign seg_uni = r_cnt[3:0];
  assign running = r_running;
  assign done    = r_done;
  assign fin     = r_fin;

endmodule

// File: doc/temporizador_mmss.md
# temporizador_mmss

Countdown timer, minutes:seconds in BCD, consuming the slow square wave `div_frec` from the frequency divider. Detects each rising edge of `div_frec` in the `clk_in` domain, turns it into a one-cycle tick and decrements a loadable MM:SS count once per tick. Includes load/start/pause control and a completion flag. Outputs drive the display multiplexer directly.

## Interface
- No parameters.
- `clk_in`  in  1  system clock; the same clock that drives the divider.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk_in` rising edge.
- `div_frec`  in  1  divided square wave; it is already in the `clk_in` domain.
- `load`  in  1  level; copies `preset` into the count and the preset register.
- `start`  in  1  level; begins or resumes counting.
- `pause`  in  1  level; suspends counting.
- `preset`  in  16  BCD digits {min_dec, min_uni, seg_dec, seg_uni}.
- `min_dec`, `min_uni`, `seg_dec`, `seg_uni`  out  4 each  current count in BCD.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `fin`  out  1  one-cycle pulse when the count reaches 00:00.

## Operation
- Edge detect: register `prev <= div_frec`. `tick = div_frec & ~prev`. `prev` resets to 1, so no false tick occurs if `div_frec` is high out of reset.
- Preset clamping, applied on load:
  - any digit > 9 becomes 9
  - seg_dec > 5 becomes 5
- The clamped value goes into both the count and the internal preset register.
- Decrement, BCD with borrow:
  - seg_uni 0→9, borrow into seg_dec
  - seg_dec 0→5, borrow into min_uni
  - min_uni 0→9, borrow into min_dec
  - the count never decrements below 00:00
- Priority within a cycle: load > pause > start > tick.
- States:
  - IDLE
    - load → reload, stay in IDLE.
    - start with count ≠ 00:00 → RUN.
    - start with count = 00:00 → ignored.
  - RUN
    - load → reload, go to IDLE.
    - pause → PAUSE. A tick in the same cycle is discarded.
    - tick → decrement.
    - tick when count = 00:01 → count becomes 00:00, `fin` pulses, go to DONE.
  - PAUSE
    - load → reload, go to IDLE.
    - start (without pause) → RUN.
    - Ticks are ignored.
  - DONE
    - load → reload, go to IDLE.
    - start and pause are ignored.
- `running` = (state == RUN). `done` = (state == DONE).

## Timing
- Every output is registered.
- Reset values:
  - state IDLE
  - all digits 0
  - preset register 0
  - `running`, `done` and `fin` all 0
- Tick latency: `div_frec` is sampled high with `prev` = 0 at edge k. The new digits are visible after edge k, and so are `fin` and `done` when applicable.
- Exactly one decrement per `div_frec` rising edge. A `div_frec` that is held high produces no further ticks.
- `fin` is high for exactly one `clk_in` cycle per expiry.
- `start` → `running` high after the next edge. The first decrement needs the next `div_frec` rising edge; it is not immediate.
- Reset asserted mid-count: all state returns to the reset values at that edge, and the preset register is cleared.

## Configuration
- `TEMP_AUTORELOAD_EN` defined:
  - On the tick at 00:01, the count reloads from the preset register in the same edge.
  - `fin` pulses and the state stays in RUN.
  - `done` is never asserted.
- Not defined: behaviour as described above, with expiry going to DONE.

## Test plan
- Reset with `div_frec` = 1 → digits 0000, state IDLE, no tick or decrement on the first cycles after reset.
- Load 16'h0103, start, drive 3 `div_frec` edges → count 01:02, then 01:01, then 01:00. One further edge → 00:59 (borrow path).
- Load 16'h0002, start, 2 edges → 00:00 one cycle after the second edge, `fin` high for exactly 1 cycle, `done` = 1. A following start leaves the count at 00:00 and `done` = 1.
- Load 16'hFF7F → count 99:59. Start with count 00:00 (load 0) → `running` stays 0.
- In RUN, pause asserted in the same cycle as a tick → count unchanged, state PAUSE. Further edges do not decrement. Start → RUN, and the next edge decrements.
- With `TEMP_AUTORELOAD_EN`: load 16'h0002, start, 4 edges → sequence 00:01, 00:00→00:02 with `fin`, 00:01, then reload to 00:02 with a second `fin`. `done` stays 0 and `running` stays 1.
